// File: rtl/lif_pkg.sv
// Shared definitions for the LIF run sequencer: default widths,
// configuration byte indices and the sequencer state encoding.
package lif_pkg;

   // Default widths
   localparam int STEP_W_DEF  = 8;
   localparam int N_LANES_DEF = 3;
   localparam int CNT_W_DEF   = 8;

   // Position of each configuration byte in the 4-byte load sequence
   localparam logic [1:0] IDX_THR   = 2'd0;
   localparam logic [1:0] IDX_DEC   = 2'd1;
   localparam logic [1:0] IDX_REF   = 2'd2;
   localparam logic [1:0] IDX_STEPS = 2'd3;

   // Sequencer state encoding
   typedef logic [2:0] lif_state_t;
   localparam lif_state_t ST_IDLE  = 3'd0;
   localparam lif_state_t ST_LOAD  = 3'd1;
   localparam lif_state_t ST_READY = 3'd2;
   localparam lif_state_t ST_CLEAR = 3'd3;
   localparam lif_state_t ST_RUN   = 3'd4;
   localparam lif_state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/lif_spike_accum.sv
// Popcount of the neuron spike lanes feeding a saturating spike counter.
// clr_i has priority over en_i; the count holds when neither is set.
module lif_spike_accum
   import lif_pkg::*;
#(
   parameter int N_LANES = N_LANES_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [N_LANES-1:0] spikes_i,
   output logic [CNT_W-1:0]   count_o
);

   localparam int POP_W = $clog2(N_LANES + 1);

   logic [POP_W-1:0] pop_count;
   logic [CNT_W:0]   sum_wide;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Number of lanes spiking this cycle
   always_comb begin
      pop_count = '0;
      for (int i = 0; i < N_LANES; i++) begin
         pop_count = pop_count + POP_W'(spikes_i[i]);
      end
   end

   // One extra bit of headroom is enough to detect overflow because the
   // per-cycle increment never exceeds N_LANES.
   always_comb begin
      sum_wide = {1'b0, count_q} + (CNT_W + 1)'(pop_count);
      count_d  = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/lif_run_sequencer.sv
// Run sequencer for the 3-lane LIF neuron: captures a 4-byte config from
// the shared byte bus, then on start clears the neuron, enables it for
// exactly N steps while counting spikes, and pulses done.
module lif_run_sequencer
   import lif_pkg::*;
#(
   parameter int STEP_W  = STEP_W_DEF,
   parameter int N_LANES = N_LANES_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid_i,
   input  logic [7:0]         cfg_data_i,
   output logic               cfg_ready_o,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [N_LANES-1:0] spike_in_i,
   output logic [7:0]         threshold_o,
   output logic [7:0]         decay_o,
   output logic [7:0]         refractory_period_o,
   output logic               neuron_en_o,
   output logic               neuron_rst_o,
   output logic               busy_o,
   output logic               cfg_loaded_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   spike_count_o
);

   lif_state_t        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        thr_q, thr_d;
   logic [7:0]        dec_q, dec_d;
   logic [7:0]        ref_q, ref_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic              en_q, rst_q, done_q;

   logic              cfg_accept;
   logic [1:0]        load_idx;
   logic              acc_clr;
   logic              acc_en;

   // Handshake and status flags decoded straight from the state; start in
   // READY withdraws cfg_ready so a colliding byte is refused, not lost.
   always_comb begin
      cfg_ready_o  = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                     ((state_q == ST_READY) && !start_i);
      busy_o       = (state_q == ST_CLEAR) || (state_q == ST_RUN);
      cfg_loaded_o = (state_q == ST_READY);
      cfg_accept   = cfg_valid_i && cfg_ready_o;
      // A byte arriving in READY always begins a fresh load sequence
      load_idx     = (state_q == ST_READY) ? IDX_THR : idx_q;
   end

   // Next-state, config capture and step-counter logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      thr_d      = thr_q;
      dec_d      = dec_q;
      ref_d      = ref_q;
      steps_d    = steps_q;
      step_cnt_d = step_cnt_q;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;

      case (state_q)
         ST_READY: begin
            if (start_i) begin
               state_d    = ST_CLEAR;
               step_cnt_d = steps_q;
               acc_clr    = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (abort_i) begin
               state_d = ST_READY;
            end else if (steps_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Spikes seen in every enabled cycle count, including the last
            // one and one cut short by abort.
            acc_en = 1'b1;
            if (abort_i) begin
               state_d = ST_READY;
            end else begin
               step_cnt_d = step_cnt_q - STEP_W'(1);
               if (step_cnt_q == STEP_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_READY;
         end
         ST_IDLE, ST_LOAD: begin
            // start and abort are ignored here; only config bytes matter
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Config bytes are only accepted in IDLE, LOAD and READY without start,
      // so this never overlaps the run transitions above.
      if (cfg_accept) begin
         case (load_idx)
            IDX_THR:   thr_d   = cfg_data_i;
            IDX_DEC:   dec_d   = cfg_data_i;
            IDX_REF:   ref_d   = cfg_data_i;
            IDX_STEPS: steps_d = STEP_W'(cfg_data_i);
            default:   thr_d   = thr_q;
         endcase
         idx_d   = load_idx + 2'd1;
         state_d = (load_idx == IDX_STEPS) ? ST_READY : ST_LOAD;
      end
   end

   // State, configuration and step counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= IDX_THR;
         thr_q      <= '0;
         dec_q      <= '0;
         ref_q      <= '0;
         steps_q    <= '0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         thr_q      <= thr_d;
         dec_q      <= dec_d;
         ref_q      <= ref_d;
         steps_q    <= steps_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   // Neuron controls and done are registered from the next state so they
   // line up exactly with the cycles spent in CLEAR, RUN and DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         rst_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         en_q   <= (state_d == ST_RUN);
         rst_q  <= (state_d == ST_CLEAR);
         done_q <= (state_d == ST_DONE);
      end
   end

   lif_spike_accum #(
      .N_LANES (N_LANES),
      .CNT_W   (CNT_W)
   ) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (acc_clr),
      .en_i     (acc_en),
      .spikes_i (spike_in_i),
      .count_o  (spike_count_o)
   );

   assign threshold_o         = thr_q;
   assign decay_o             = dec_q;
   assign refractory_period_o = ref_q;
   assign neuron_en_o         = en_q;
   assign neuron_rst_o        = rst_q;
   assign done_o              = done_q;

endmodule

// File: tb/tb_lif_run_sequencer.sv
// Randomised self-checking bench for lif_run_sequencer. The reference is a
// run-level model: the stored config bytes plus, for each run, which cycle
// after the start edge should show neuron_rst, neuron_en and done, and the
// saturated sum of spikes driven during the enabled cycles.
module tb_lif_run_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_data = 8'h00;
   logic       cfg_ready;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] spike_in = 3'b000;
   logic [7:0] threshold, decay, refractory_period;
   logic       neuron_en, neuron_rst, busy, cfg_loaded, done;
   logic [7:0] spike_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] m_cfg [4];
   int         m_idx   = 0;
   int         m_ready = 0;

   always #5 clk = ~clk;

   lif_run_sequencer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cfg_valid_i         (cfg_valid),
      .cfg_data_i          (cfg_data),
      .cfg_ready_o         (cfg_ready),
      .start_i             (start),
      .abort_i             (abort),
      .spike_in_i          (spike_in),
      .threshold_o         (threshold),
      .decay_o             (decay),
      .refractory_period_o (refractory_period),
      .neuron_en_o         (neuron_en),
      .neuron_rst_o        (neuron_rst),
      .busy_o              (busy),
      .cfg_loaded_o        (cfg_loaded),
      .done_o              (done),
      .spike_count_o       (spike_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
      m_idx   = 0;
      m_ready = 0;
   endtask

   // Outputs expected whenever no run is in progress
   task automatic chk_quiet(input string tag);
      chk({tag, ".thr"}, threshold, m_cfg[0]);
      chk({tag, ".dec"}, decay, m_cfg[1]);
      chk({tag, ".ref"}, refractory_period, m_cfg[2]);
      chk({tag, ".loaded"}, cfg_loaded, m_ready);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".en"}, neuron_en, 0);
      chk({tag, ".nrst"}, neuron_rst, 0);
      chk({tag, ".done"}, done, 0);
   endtask

   // One config byte; called and returns at a falling edge
   task automatic load_byte(input logic [7:0] b);
      cfg_valid = 1'b1;
      cfg_data  = b;
      #1 chk("load.ready", cfg_ready, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      m_cfg[m_idx] = b;
      m_idx   = (m_idx + 1) % 4;
      m_ready = (m_idx == 0) ? 1 : 0;
      chk_quiet("load");
   endtask

   task automatic load_cfg(input logic [7:0] t, input logic [7:0] d,
                           input logic [7:0] r, input logic [7:0] n);
      load_byte(t);
      load_byte(d);
      load_byte(r);
      load_byte(n);
      $display("cfg  thr=%02h dec=%02h ref=%02h steps=%0d", t, d, r, n);
   endtask

   // One run from READY. abort_at = cycle index (1 = CLEAR) at which abort
   // is driven, 0 for none. mode: 0 random spikes, 1 all lanes, 2 silent.
   task automatic do_run(input int abort_at, input int mode, input bit collide);
      int         n;
      int         k_end;
      int         acc;
      int         en_cycles;
      int         done_at;
      bit         en_e, last;
      logic [2:0] sp;
      n         = int'(m_cfg[3]);
      acc       = 0;
      en_cycles = 0;
      done_at   = 0;
      k_end     = (abort_at != 0) ? abort_at + 1 : n + 3;
      start = 1'b1;
      if (collide) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'($urandom);
      end
      #1 chk("run.start_ready", cfg_ready, 0);
      @(negedge clk);
      start     = 1'b0;
      cfg_valid = 1'b0;
      for (int k = 1; k <= k_end; k++) begin
         last = (k == k_end);
         en_e = (k >= 2) && (k <= n + 1) && (abort_at == 0 || k <= abort_at);
         chk("run.nrst", neuron_rst, (k == 1) ? 1 : 0);
         chk("run.en", neuron_en, en_e);
         chk("run.done", done, (abort_at == 0 && k == n + 2) ? 1 : 0);
         chk("run.busy", busy, (!last && k <= n + 1) ? 1 : 0);
         chk("run.cfg_ready", cfg_ready, last ? 1 : 0);
         chk("run.count", spike_count, acc);
         chk("run.thr", threshold, m_cfg[0]);
         chk("run.dec", decay, m_cfg[1]);
         chk("run.ref", refractory_period, m_cfg[2]);
         if (neuron_en === 1'b1) en_cycles++;
         if (done === 1'b1) done_at = k;
         if (last) begin
            spike_in  = 3'b000;
            abort     = 1'b0;
            cfg_valid = 1'b0;
         end else begin
            case (mode)
               1:       sp = 3'b111;
               2:       sp = 3'b000;
               default: sp = 3'($urandom);
            endcase
            spike_in = sp;
            if (en_e) acc = (acc + $countones(sp) > 255) ? 255 : acc + $countones(sp);
            // abort in DONE must be ignored
            abort     = (k == abort_at) || (abort_at == 0 && k == n + 2 && $urandom_range(0, 1) == 1);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      chk("run.loaded", cfg_loaded, 1);
      m_ready = 1;
      $display("run  steps=%0d abort_at=%0d en_cycles=%0d done_cycle=%0d count=%0d",
               n, abort_at, en_cycles, done_at, spike_count);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.count", spike_count, 0);
      chk("rst.cfg_ready", cfg_ready, 1);
      chk_quiet("rst");

      // Basic run, all lanes spiking, then a silent run on the same config
      load_cfg(8'h40, 8'h02, 8'h05, 8'h04);
      do_run(0, 1, 0);
      chk("run1.total", spike_count, 12);
      do_run(0, 2, 0);
      chk("run2.total", spike_count, 0);

      // start during LOAD is ignored; then a zero-step run
      load_byte(8'h11);
      load_byte(8'h22);
      start = 1'b1;
      #1 chk("loadstart.ready", cfg_ready, 1);
      @(negedge clk);
      start = 1'b0;
      chk_quiet("loadstart");
      load_byte(8'h33);
      load_byte(8'h00);
      $display("cfg  partial load, start ignored, steps=0");
      do_run(0, 1, 0);
      chk("zero.total", spike_count, 0);

      // Saturating run of 255 steps
      load_cfg(8'h7f, 8'h01, 8'h02, 8'hff);
      do_run(0, 1, 0);
      chk("sat.total", spike_count, 255);

      // start colliding with a config byte, then abort on the second RUN cycle
      load_cfg(8'h40, 8'h02, 8'h05, 8'h04);
      do_run(0, 0, 1);
      do_run(3, 1, 0);
      chk("abort.partial", spike_count, 6);
      chk_quiet("abort");

      // Randomised configs and runs
      for (int it = 0; it < 24; it++) begin
         int n;
         int ab;
         n  = $urandom_range(0, 12);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : 0;
         load_cfg(8'($urandom), 8'($urandom), 8'($urandom), 8'(n));
         do_run(ab, $urandom_range(0, 2), $urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) do_run(0, 0, 0);
      end

      // Asynchronous reset in the middle of a run
      load_cfg(8'h55, 8'h66, 8'h77, 8'h08);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      spike_in = 3'b111;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.en", neuron_en, 0);
      chk("arst.count", spike_count, 0);
      chk("arst.cfg_ready", cfg_ready, 1);
      chk_quiet("arst");
      @(negedge clk);
      rst_n    = 1'b1;
      spike_in = 3'b000;
      @(negedge clk);
      chk_quiet("arst.post");
      $display("rst  asynchronous reset during run");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
